// File: rtl/board_updater_if.sv
// Board RAM port B bundle.
// The updater drives address / write data / write enable (master) and
// the RAM returns read data RD_LAT cycles after the address (slave).
//   ram_addr  : block index, 0..1023 (only 0..N_BLOCKS-1 are real tiles)
//   ram_wdata : 4-bit tile code
//   ram_wren  : write strobe
//   ram_q     : read data
interface board_updater_if;
    logic [9:0] ram_addr;
    logic [3:0] ram_wdata;
    logic       ram_wren;
    logic [3:0] ram_q;

    modport master (output ram_addr, output ram_wdata, output ram_wren, input ram_q);
    modport slave  (input ram_addr, input ram_wdata, input ram_wren, output ram_q);
endinterface

// File: rtl/board_updater.sv
// Game-step sequencer committing Pac-Man and ghost moves into the board RAM.
// On each accepted tick, entities are visited in order pac, blinky, clyde,
// inky, pinky: moves into walls or off the board are rejected, the vacated
// tile is restored (empty for pac, the remembered under-tile for ghosts),
// the entity code is stamped at the new tile, pellets eaten by pac are
// counted and a ghost/pac collision is flagged.
//
// Ports
//   clk, rst_n      : system clock, asynchronous active-low reset
//   tick_i          : one-cycle game-step strobe, only honoured when idle
//   cur_locs_i      : {pinky, inky, clyde, blinky, pac}, 10 bits each
//   next_locs_i     : requested locations, same packing
//   ram             : board RAM port B (master side)
//   busy_o          : step in progress
//   done_o          : one-cycle pulse at end of step
//   move_ok_o       : accepted-move mask, bit i = entity i
//   score_o         : pellets eaten, saturating
//   caught_o        : collision flag for the last step
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for tick; latch locations on tick
// SKIP  | entity not moving or target off board, 1 cycle
// READ  | present target address to RAM
// WAIT  | wait out remaining RAM read latency
// EVAL  | sample target tile; wall blocks, else restore vacated tile
// WRITE | stamp entity code on target, update under-tile / score
// CHECK | evaluate collision from effective locations
// DONE  | done pulse, back to IDLE
module board_updater #(
    parameter int N_BLOCKS = 768,
    parameter int RD_LAT   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tick_i,
    input  logic [49:0]            cur_locs_i,
    input  logic [49:0]            next_locs_i,
    board_updater_if.master        ram,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [4:0]             move_ok_o,
    output logic [15:0]            score_o,
    output logic                   caught_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SKIP  = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_EVAL  = 3'd4;
    localparam logic [2:0] S_WRITE = 3'd5;
    localparam logic [2:0] S_CHECK = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    localparam logic [3:0] T_EMPTY  = 4'd0;
    localparam logic [3:0] T_WALL   = 4'd1;
    localparam logic [3:0] T_PELLET = 4'd2;
    localparam logic [3:0] T_PAC    = 4'd3;

    // WAIT lasts RD_LAT-1 cycles; the counter holds the extra cycles left
    // after the first WAIT cycle, so it is loaded with RD_LAT-2.
    localparam int               WCW       = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
    localparam logic [WCW-1:0]   WAIT_LOAD = (RD_LAT > 2) ? WCW'(RD_LAT - 2) : '0;

    logic [2:0]     state_q, state_d;
    logic [2:0]     idx_q, idx_d;
    logic [9:0]     cur_q [5];
    logic [9:0]     cur_d [5];
    logic [9:0]     nxt_q [5];
    logic [9:0]     nxt_d [5];
    // Entry 0 (pac) is never written and stays empty, so the restore tile
    // can be read uniformly as under_q[idx].
    logic [3:0]     under_q [5];
    logic [3:0]     under_d [5];
    logic [3:0]     qs_q, qs_d;
    logic [WCW-1:0] wait_q, wait_d;
    logic [4:0]     move_ok_q, move_ok_d;
    logic [15:0]    score_q, score_d;
    logic           caught_q, caught_d;

    logic           last_ent;
    logic [2:0]     idx_nx;
    logic [2:0]     adv_st;
    logic           hit;
    logic [9:0]     pac_eff;
    logic [9:0]     g_eff;

    function automatic logic [2:0] route(input logic [9:0] c, input logic [9:0] n);
        if ((n == c) || (int'(n) >= N_BLOCKS)) return S_SKIP;
        return S_READ;
    endfunction

    // Collision: same effective tile, or pac and a ghost swapped places.
    always_comb begin
        hit     = 1'b0;
        g_eff   = '0;
        pac_eff = move_ok_q[0] ? nxt_q[0] : cur_q[0];
        for (int g = 1; g < 5; g++) begin
            g_eff = move_ok_q[g] ? nxt_q[g] : cur_q[g];
            if (g_eff == pac_eff) hit = 1'b1;
            if (move_ok_q[0] && move_ok_q[g] &&
                (cur_q[0] == nxt_q[g]) && (cur_q[g] == nxt_q[0])) hit = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cur_d     = cur_q;
        nxt_d     = nxt_q;
        under_d   = under_q;
        qs_d      = qs_q;
        wait_d    = wait_q;
        move_ok_d = move_ok_q;
        score_d   = score_q;
        caught_d  = caught_q;

        ram.ram_addr  = '0;
        ram.ram_wdata = T_EMPTY;
        ram.ram_wren  = 1'b0;

        // Index stays at 4 after the last entity so array reads stay in range.
        last_ent = (idx_q >= 3'd4);
        idx_nx   = last_ent ? idx_q : idx_q + 3'd1;
        adv_st   = last_ent ? S_CHECK : route(cur_q[idx_nx], nxt_q[idx_nx]);

        case (state_q)
            S_IDLE: begin
                if (tick_i) begin
                    for (int k = 0; k < 5; k++) begin
                        cur_d[k] = cur_locs_i[10*k +: 10];
                        nxt_d[k] = next_locs_i[10*k +: 10];
                    end
                    idx_d     = 3'd0;
                    move_ok_d = 5'd0;
                    caught_d  = 1'b0;
                    state_d   = route(cur_locs_i[9:0], next_locs_i[9:0]);
                end
            end
            S_SKIP: begin
                idx_d   = idx_nx;
                state_d = adv_st;
            end
            S_READ: begin
                ram.ram_addr = nxt_q[idx_q];
                if (RD_LAT <= 1) begin
                    state_d = S_EVAL;
                end else begin
                    wait_d  = WAIT_LOAD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                ram.ram_addr = nxt_q[idx_q];
                if (wait_q == '0) state_d = S_EVAL;
                else              wait_d  = wait_q - WCW'(1);
            end
            S_EVAL: begin
                qs_d = ram.ram_q;
                if (ram.ram_q == T_WALL) begin
                    idx_d   = idx_nx;
                    state_d = adv_st;
                end else begin
                    ram.ram_wren  = 1'b1;
                    ram.ram_addr  = cur_q[idx_q];
                    ram.ram_wdata = under_q[idx_q];
                    state_d       = S_WRITE;
                end
            end
            S_WRITE: begin
                ram.ram_wren       = 1'b1;
                ram.ram_addr       = nxt_q[idx_q];
                ram.ram_wdata      = T_PAC + {1'b0, idx_q};
                move_ok_d[idx_q]   = 1'b1;
                if (idx_q == 3'd0) begin
                    if ((qs_q == T_PELLET) && (score_q != 16'hFFFF))
                        score_d = score_q + 16'd1;
                end else begin
                    // Only pellets are remembered; walls and entity codes are not.
                    under_d[idx_q] = (qs_q == T_PELLET) ? T_PELLET : T_EMPTY;
                end
                idx_d   = idx_nx;
                state_d = adv_st;
            end
            S_CHECK: begin
                caught_d = hit;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= 3'd0;
            qs_q      <= T_EMPTY;
            wait_q    <= '0;
            move_ok_q <= 5'd0;
            score_q   <= 16'd0;
            caught_q  <= 1'b0;
            for (int k = 0; k < 5; k++) begin
                cur_q[k]   <= '0;
                nxt_q[k]   <= '0;
                under_q[k] <= T_EMPTY;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            qs_q      <= qs_d;
            wait_q    <= wait_d;
            move_ok_q <= move_ok_d;
            score_q   <= score_d;
            caught_q  <= caught_d;
            cur_q     <= cur_d;
            nxt_q     <= nxt_d;
            under_q   <= under_d;
        end
    end

    assign busy_o    = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o    = (state_q == S_DONE);
    assign move_ok_o = move_ok_q;
    assign score_o   = score_q;
    assign caught_o  = caught_q;

endmodule
